// File: rtl/fanctrl_pkg.sv
// Shared types and sizing helpers for the fan-controller PID datapath.
package fanctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapture = 3'd1,
    StMac0    = 3'd2,
    StMac1    = 3'd3,
    StMac2    = 3'd4,
    StUpdate  = 3'd5
  } state_e;

  function automatic int acc_width(input int adc_bw, input int coeff_bw);
    return adc_bw + coeff_bw + 3;
  endfunction

  function automatic int u_min(input int adc_bw, input int frac_bits);
    return -((2 ** adc_bw) << frac_bits);
  endfunction

  function automatic int u_max(input int adc_bw, input int frac_bits);
    return (((2 ** adc_bw) - 1) << frac_bits) + ((2 ** frac_bits) - 1);
  endfunction

endpackage

// File: rtl/pid_mac_unit.sv
// Shared signed multiply-accumulate; clr restarts the sum with the current product.
module pid_mac_unit
  import fanctrl_pkg::*;
#(
  parameter int unsigned XW   = 5,
  parameter int unsigned CW   = 8,
  parameter int unsigned AccW = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [CW-1:0]   coeff_i,
  input  logic signed [XW-1:0]   x_i,
  output logic signed [AccW-1:0] acc_o
);

  localparam int unsigned PW = XW + CW;

  logic signed [PW-1:0]   coeff_ext, x_ext, prod;
  logic signed [AccW-1:0] prod_ext, base, acc_q, acc_d;

  always_comb begin
    coeff_ext = $signed({{XW{coeff_i[CW-1]}}, coeff_i});
    x_ext     = $signed({{CW{x_i[XW-1]}}, x_i});
    prod      = coeff_ext * x_ext;
    prod_ext  = $signed({{(AccW - PW){prod[PW-1]}}, prod});
    base      = clr_i ? '0 : acc_q;
    acc_d     = en_i ? (base + prod_ext) : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pid_stage_scheduler.sv
// Fixed five-stage incremental PID sequencer driven by an inline sample-tick divider.
module pid_stage_scheduler
  import fanctrl_pkg::*;
#(
  parameter int unsigned ADC_BITWIDTH   = 4,
  parameter int unsigned CLK_DIV        = 199999,
  parameter int unsigned COEFF_BITWIDTH = 8,
  parameter int unsigned FRAC_BITS      = 4,
  parameter int          B0             = 16,
  parameter int          B1             = -8,
  parameter int          B2             = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic        [ADC_BITWIDTH-1:0] adc_val,
  input  logic        [ADC_BITWIDTH-1:0] set_val,
  output logic signed [ADC_BITWIDTH:0]   pid_val,
  output logic                           pid_valid,
  output logic                           tick,
  output logic                           busy,
  output logic        [2:0]              stage
);

  localparam int unsigned EW   = ADC_BITWIDTH + 1;
  localparam int unsigned CW   = COEFF_BITWIDTH;
  localparam int unsigned AccW = acc_width(ADC_BITWIDTH, COEFF_BITWIDTH);
  localparam int unsigned CntW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);

  localparam logic signed [AccW:0] UMin = (AccW + 1)'(u_min(ADC_BITWIDTH, FRAC_BITS));
  localparam logic signed [AccW:0] UMax = (AccW + 1)'(u_max(ADC_BITWIDTH, FRAC_BITS));

  localparam logic signed [CW-1:0] CoefB0 = CW'(B0);
  localparam logic signed [CW-1:0] CoefB1 = CW'(B1);
  localparam logic signed [CW-1:0] CoefB2 = CW'(B2);

  if (CLK_DIV < 5) begin : g_clk_div_check
    $error("pid_stage_scheduler: CLK_DIV must be >= 5");
  end

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic signed [EW-1:0]   e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [AccW-1:0] u_q, u_d, u_clamp;
  logic signed [AccW:0]   u_sum;
  logic signed [EW-1:0]   pid_q, pid_d;
  logic                   valid_q, valid_d;

  logic                   mac_clr, mac_en;
  logic signed [CW-1:0]   mac_coeff;
  logic signed [EW-1:0]   mac_x;
  logic signed [AccW-1:0] acc;

  assign tick = ena && (cnt_q == CntW'(CLK_DIV));

  always_comb begin
    cnt_d = cnt_q;
    if (ena) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // One extra bit on the sum so the clamp sees the true value before any wrap.
  always_comb begin
    u_sum   = $signed({u_q[AccW-1], u_q}) + $signed({acc[AccW-1], acc});
    u_clamp = u_sum[AccW-1:0];
    if (u_sum > UMax)      u_clamp = UMax[AccW-1:0];
    else if (u_sum < UMin) u_clamp = UMin[AccW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    u_d       = u_q;
    pid_d     = pid_q;
    valid_d   = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    mac_coeff = CoefB0;
    mac_x     = e0_q;
    unique case (state_q)
      StIdle: if (tick) state_d = StCapture;
      StCapture: begin
        e0_d    = $signed({1'b0, set_val}) - $signed({1'b0, adc_val});
        state_d = StMac0;
      end
      StMac0: begin
        mac_clr = 1'b1;
        mac_en  = 1'b1;
        state_d = StMac1;
      end
      StMac1: begin
        mac_en    = 1'b1;
        mac_coeff = CoefB1;
        mac_x     = e1_q;
        state_d   = StMac2;
      end
      StMac2: begin
        mac_en    = 1'b1;
        mac_coeff = CoefB2;
        mac_x     = e2_q;
        state_d   = StUpdate;
      end
      StUpdate: begin
        u_d     = u_clamp;
        e2_d    = e1_q;
        e1_d    = e0_q;
        // Clamped value is in range, so the bit slice is exactly a floor shift.
        pid_d   = u_clamp[FRAC_BITS+ADC_BITWIDTH -: EW];
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      u_q     <= '0;
      pid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      u_q     <= u_d;
      pid_q   <= pid_d;
      valid_q <= valid_d;
    end
  end

  pid_mac_unit #(
    .XW   (EW),
    .CW   (CW),
    .AccW (AccW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .coeff_i (mac_coeff),
    .x_i     (mac_x),
    .acc_o   (acc)
  );

  assign pid_val   = pid_q;
  assign pid_valid = valid_q;
  assign busy      = (state_q != StIdle);
  assign stage     = state_q;

endmodule

// File: tb/tb_pid_stage_scheduler.sv
// Directed plus randomized bench for pid_stage_scheduler against an integer PID model.
module tb_pid_stage_scheduler;

  localparam int CLK_DIV = 9;
  localparam int MB0 = 16, MB1 = -8, MB2 = 0;
  localparam int MUMIN = -(16 * 16);
  localparam int MUMAX = 15 * 16 + 15;

  logic              clk = 1'b0;
  logic              rst, ena;
  logic        [3:0] adc_val, set_val;
  logic signed [4:0] pid_val;
  logic              pid_valid, tick, busy;
  logic        [2:0] stage;

  int vectors = 0, errs = 0;
  int cyc = 0, last_tick = -1;
  int mu = 0, me1 = 0, me2 = 0;

  pid_stage_scheduler #(
    .ADC_BITWIDTH   (4),
    .CLK_DIV        (CLK_DIV),
    .COEFF_BITWIDTH (8),
    .FRAC_BITS      (4),
    .B0             (16),
    .B1             (-8),
    .B2             (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .adc_val   (adc_val),
    .set_val   (set_val),
    .pid_val   (pid_val),
    .pid_valid (pid_valid),
    .tick      (tick),
    .busy      (busy),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_clk();
    check("rst_pid_val", 32'($signed(pid_val)), 0);
    check("rst_pid_valid", 32'(pid_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stage", 32'(stage), 0);
    check("rst_tick", 32'(tick), 0);
    rst = 1'b0;
    cyc = 0;
    last_tick = -1;
    mu = 0; me1 = 0; me2 = 0;
  endtask

  // Wait for a tick, then follow the six-cycle sequence and compare against the model.
  task automatic run_seq(input int adc, input int setv, input int exp_tick,
                         input int drop_k, input int abort_k);
    int n, e0, un, ep;
    adc_val = adc[3:0];
    set_val = setv[3:0];
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (tick !== 1'b1 && n < 60);
    check("tick_seen", 32'(tick), 1);
    if (exp_tick >= 0) check("tick_cycle", cyc, exp_tick);
    else if (last_tick >= 0) check("tick_period", cyc - last_tick, CLK_DIV + 1);
    last_tick = cyc;

    e0 = setv - adc;
    un = mu + MB0 * e0 + MB1 * me1 + MB2 * me2;
    if (un > MUMAX) un = MUMAX;
    if (un < MUMIN) un = MUMIN;
    ep = un >>> 4;

    for (int k = 1; k <= 6; k++) begin
      tick_clk();
      if (k == abort_k) begin
        do_reset();
        return;
      end
      if (k == drop_k) ena = 1'b0;
      check("busy", 32'(busy), 32'(k <= 5));
      check("stage", 32'(stage), (k <= 5) ? k : 0);
      check("pid_valid", 32'(pid_valid), 32'(k == 6));
    end
    check("pid_val", 32'($signed(pid_val)), ep);
    mu = un; me2 = me1; me1 = e0;
    tick_clk();
    check("pid_hold", 32'($signed(pid_val)), ep);
    check("valid_pulse_end", 32'(pid_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_ramp[4];
    int nticks, nvalid, en_cyc;
    exp_ramp = '{-2, -3, -4, -5};
    rst = 1'b1; ena = 1'b1; adc_val = '0; set_val = '0;

    // Latency from reset release, then random samples
    do_reset();
    check("cycle0_tick", 32'(tick), 0);
    run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), CLK_DIV, 0, 0);
    for (int i = 0; i < 8; i++)
      run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, 0, 0);

    // Integration with constant error of -2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_seq(7, 5, (i == 0) ? CLK_DIV : -1, 0, 0);
      check("ramp_value", 32'($signed(pid_val)), exp_ramp[i]);
    end

    // Negative saturation, then recovery without windup
    for (int i = 0; i < 6; i++) run_seq(15, 0, -1, 0, 0);
    check("sat_neg", 32'($signed(pid_val)), -16);
    run_seq(0, 15, -1, 0, 0);
    check("unwind", 32'($signed(pid_val) != -16), 1);

    // Positive saturation
    for (int i = 0; i < 5; i++) begin
      run_seq(0, 15, -1, 0, 0);
      check("no_wrap", 32'($signed(pid_val) >= 0), 1);
    end
    check("sat_pos", 32'($signed(pid_val)), 15);

    // ena drops during MAC1: sequence completes, divider frozen at 2
    run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, 3, 0);
    nticks = 0;
    for (int i = 0; i < 25; i++) begin
      tick_clk();
      if (tick === 1'b1) nticks++;
    end
    check("ena_low_ticks", nticks, 0);
    ena = 1'b1;
    en_cyc = cyc;
    last_tick = -1;
    run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            en_cyc + CLK_DIV - 2, 0, 0);

    // Reset during MAC1 aborts the sequence
    run_seq(3, 12, -1, 0, 3);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick_clk();
      if (pid_valid === 1'b1) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    do_reset();
    run_seq(3, 12, CLK_DIV, 0, 0);
    check("fresh_result", 32'($signed(pid_val)), 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
